score_display_seq: RTL and testbench

Parametrised, sequential binary-to-seven-segment score display. It converts an unsigned binary score to DIGITS decimal digits using an iterative shift-and-add-3 (double-dabble) datapath, one bit per cycle, with no divider. It adds optional leading-zero blanking, an overflow indication, and a one-deep pending buffer for scores that arrive mid-conversion. It sits between the game-logic score counter and the board HEX displays, and drives active-low segments that hold steady between updates.

---
 rtl/score_display_pkg.sv | 14 +
 rtl/score_display_if.sv | 25 ++
 rtl/score_display_seq_seg7.sv | 25 ++
 rtl/score_display_seq.sv | 136 +++++++++++++
 tb/tb_score_display_seq.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/score_display_pkg.sv
// Shared types, segment constants and the BCD nibble adjust
// for the sequential score display.
`timescale 1ns/1ps
package score_display_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction
endpackage

// File: rtl/score_display_if.sv
// Request/result bundle between the score counter and the display.
`timescale 1ns/1ps
interface score_display_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 3
);
    import score_display_pkg::*;

    logic                  start;
    logic [WIDTH-1:0]      value;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [7*DIGITS-1:0]   hex;

    modport master (
        output start, value,
        input  busy, done, overflow, hex
    );

    modport slave (
        input  start, value,
        output busy, done, overflow, hex
    );
endinterface

// File: rtl/score_display_seq_seg7.sv
// BCD to active-low seven-segment decoder {g,f,e,d,c,b,a}.
`timescale 1ns/1ps
module seg7
    import score_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] leds
);
    always_comb begin
        leds = SEG_BLANK;
        case (bcd)
            4'd0: leds = 7'b1000000;
            4'd1: leds = 7'b1111001;
            4'd2: leds = 7'b0100100;
            4'd3: leds = 7'b0110000;
            4'd4: leds = 7'b0011001;
            4'd5: leds = 7'b0010010;
            4'd6: leds = 7'b0000010;
            4'd7: leds = 7'b1111000;
            4'd8: leds = 7'b0000000;
            4'd9: leds = 7'b0010000;
            default: leds = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/score_display_seq.sv
// Iterative double-dabble score converter driving DIGITS
// registered seven-segment displays, with a one-deep pending slot.
`timescale 1ns/1ps
module score_display_seq
    import score_display_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int DIGITS        = 3,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic           clk,
    input  logic           reset_n,
    score_display_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    function automatic logic [7*DIGITS-1:0] reset_hex();
        logic [7*DIGITS-1:0] h;
        h = {DIGITS{BLANK_LEADING ? SEG_BLANK : SEG_ZERO}};
        h[6:0] = SEG_ZERO;
        return h;
    endfunction

    localparam logic [7*DIGITS-1:0] HEX_RST = reset_hex();

    state_t              state, state_nxt;
    logic [WIDTH-1:0]    bin, pend, launch_val;
    logic                pend_vld, launch, sticky;
    logic [BW-1:0]       bcd, bcd_adj;
    logic [CW-1:0]       cnt;
    logic [6:0]          dec [DIGITS];
    logic [7*DIGITS-1:0] seg_nxt, hex_q;
    logic                ovf_q, done_q, lead;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // A start seen in LOAD bypasses the pending slot and launches at once.
    always_comb begin
        state_nxt  = state;
        launch     = 1'b0;
        launch_val = bus.value;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = SHIFT;
                    launch    = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt == CW'(1)) state_nxt = LOAD;
            end
            LOAD: begin
                if (bus.start || pend_vld) begin
                    state_nxt  = SHIFT;
                    launch     = 1'b1;
                    launch_val = bus.start ? bus.value : pend;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < DIGITS; i++)
            bcd_adj[4*i +: 4] = add3(bcd[4*i +: 4]);
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        seg7 u_seg7 (
            .bcd  (bcd[4*g +: 4]),
            .leds (dec[g])
        );
    end

    // lead stays set while every digit above i is zero.
    always_comb begin
        seg_nxt = '0;
        lead    = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (sticky)
                seg_nxt[7*i +: 7] = SEG_DASH;
            else if (BLANK_LEADING && i > 0 && lead && bcd[4*i +: 4] == 4'd0)
                seg_nxt[7*i +: 7] = SEG_BLANK;
            else
                seg_nxt[7*i +: 7] = dec[i];
            if (bcd[4*i +: 4] != 4'd0) lead = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin      <= '0;
            bcd      <= '0;
            cnt      <= '0;
            sticky   <= 1'b0;
            pend     <= '0;
            pend_vld <= 1'b0;
            hex_q    <= HEX_RST;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (launch) begin
                bin    <= launch_val;
                bcd    <= '0;
                sticky <= 1'b0;
                cnt    <= CW'(WIDTH);
            end else if (state == SHIFT) begin
                {bcd, bin} <= {bcd_adj, bin} << 1;
                sticky     <= sticky | bcd_adj[BW-1];
                cnt        <= cnt - CW'(1);
            end
            if (state == LOAD) begin
                hex_q    <= seg_nxt;
                ovf_q    <= sticky;
                done_q   <= 1'b1;
                pend_vld <= 1'b0;
            end else if (bus.start && state != IDLE) begin
                pend     <= bus.value;
                pend_vld <= 1'b1;
            end
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;
    assign bus.hex      = hex_q;
endmodule

// File: tb/tb_score_display_seq.sv
// Randomised bench for score_display_seq against a decimal
// arithmetic model of the display.
`timescale 1ns/1ps
module tb_score_display_seq;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [15:0] value_a = '0;
    logic [19:0] value_b = '0;
    int          compared = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    score_display_if #(.WIDTH(16), .DIGITS(3)) if_a ();
    score_display_if #(.WIDTH(16), .DIGITS(3)) if_n ();
    score_display_if #(.WIDTH(20), .DIGITS(6)) if_6 ();
    score_display_if #(.WIDTH(20), .DIGITS(7)) if_7 ();

    assign if_a.start = start_a;
    assign if_a.value = value_a;
    assign if_n.start = start_a;
    assign if_n.value = value_a;
    assign if_6.start = start_b;
    assign if_6.value = value_b;
    assign if_7.start = start_b;
    assign if_7.value = value_b;

    score_display_seq #(.WIDTH(16), .DIGITS(3), .BLANK_LEADING(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(if_a));
    score_display_seq #(.WIDTH(16), .DIGITS(3), .BLANK_LEADING(1'b0)) dut_n (
        .clk(clk), .reset_n(reset_n), .bus(if_n));
    score_display_seq #(.WIDTH(20), .DIGITS(6), .BLANK_LEADING(1'b1)) dut_6 (
        .clk(clk), .reset_n(reset_n), .bus(if_6));
    score_display_seq #(.WIDTH(20), .DIGITS(7), .BLANK_LEADING(1'b1)) dut_7 (
        .clk(clk), .reset_n(reset_n), .bus(if_7));

    logic [6:0] seg_tab [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    function automatic longint unsigned pow10(input int n);
        longint unsigned p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic bit model_ovf(input longint unsigned v, input int digits);
        return v >= pow10(digits);
    endfunction

    function automatic logic [48:0] model_hex(input longint unsigned v,
                                              input int digits, input bit blank);
        logic [48:0] h = '0;
        for (int i = 0; i < digits; i++) begin
            if (model_ovf(v, digits))
                h[7*i +: 7] = 7'b0111111;
            else if (blank && i > 0 && v < pow10(i))
                h[7*i +: 7] = 7'h7F;
            else
                h[7*i +: 7] = seg_tab[int'((v / pow10(i)) % 10)];
        end
        return h;
    endfunction

    task automatic drive_a(input logic [15:0] v);
        @(negedge clk);
        start_a = 1'b1;
        value_a = v;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic run_and_check_a(input logic [15:0] v, input string name);
        int          lat = 0;
        logic        busy0;
        logic [48:0] ea, en;
        drive_a(v);
        busy0 = if_a.busy;
        while (if_a.done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        ea = model_hex(v, 3, 1'b1);
        en = model_hex(v, 3, 1'b0);
        compared++;
        if (busy0 !== 1'b1) begin
            $display("FAIL %s busy: got %b want 1", name, busy0);
            mismatched++;
        end
        compared++;
        if (lat !== 17) begin
            $display("FAIL %s latency: got %0d want 17", name, lat);
            mismatched++;
        end
        compared++;
        if (if_a.hex !== ea[20:0]) begin
            $display("FAIL %s hex: got %h want %h", name, if_a.hex, ea[20:0]);
            mismatched++;
        end
        compared++;
        if (if_a.overflow !== model_ovf(v, 3)) begin
            $display("FAIL %s overflow: got %b want %b", name, if_a.overflow, model_ovf(v, 3));
            mismatched++;
        end
        compared++;
        if (if_n.done !== 1'b1 || if_n.hex !== en[20:0]) begin
            $display("FAIL %s noblank: got done=%b hex=%h want 1 %h",
                     name, if_n.done, if_n.hex, en[20:0]);
            mismatched++;
        end
        @(negedge clk);
        compared++;
        if (if_a.done !== 1'b0 || if_a.busy !== 1'b0) begin
            $display("FAIL %s pulse: got done=%b busy=%b want 0 0", name, if_a.done, if_a.busy);
            mismatched++;
        end
    endtask

    task automatic test_reset();
        logic [48:0] ea, en, e7;
        ea = model_hex(0, 3, 1'b1);
        en = model_hex(0, 3, 1'b0);
        e7 = model_hex(0, 7, 1'b1);
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if (if_a.busy !== 1'b0 || if_a.done !== 1'b0 || if_a.overflow !== 1'b0) begin
            $display("FAIL reset flags: got %b%b%b want 000", if_a.busy, if_a.done, if_a.overflow);
            mismatched++;
        end
        compared++;
        if (if_a.hex !== ea[20:0]) begin
            $display("FAIL reset hex: got %h want %h", if_a.hex, ea[20:0]);
            mismatched++;
        end
        compared++;
        if (if_n.hex !== en[20:0]) begin
            $display("FAIL reset hex_noblank: got %h want %h", if_n.hex, en[20:0]);
            mismatched++;
        end
        compared++;
        if (if_7.hex !== e7) begin
            $display("FAIL reset hex7: got %h want %h", if_7.hex, e7);
            mismatched++;
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if (if_a.hex !== ea[20:0] || if_a.busy !== 1'b0) begin
            $display("FAIL idle hold: got %h busy=%b want %h 0", if_a.hex, if_a.busy, ea[20:0]);
            mismatched++;
        end
    endtask

    task automatic test_fixed();
        run_and_check_a(16'd255, "v255");
        run_and_check_a(16'd7, "v7");
        run_and_check_a(16'd1000, "v1000");
        run_and_check_a(16'd0, "v0");
        run_and_check_a(16'd999, "v999");
        run_and_check_a(16'd65535, "v65535");
    endtask

    task automatic test_random();
        logic [15:0] v;
        for (int k = 0; k < 20; k++) begin
            case ($urandom_range(0, 3))
                0: v = 16'($urandom_range(0, 9));
                1: v = 16'($urandom_range(0, 999));
                2: v = 16'($urandom_range(990, 1010));
                default: v = 16'($urandom_range(0, 65535));
            endcase
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_and_check_a(v, "random");
        end
    endtask

    task automatic test_overlap(input logic [15:0] v1, input logic [15:0] v2,
                                input logic [15:0] v3, input int c2, input int c3,
                                input string name);
        int          ndone = 0;
        int          c1st = -1;
        int          c2nd = -1;
        int          gaps = 0;
        logic [20:0] h1 = '0;
        logic [20:0] h2 = '0;
        logic [48:0] e1, e2;
        e1 = model_hex(v1, 3, 1'b1);
        e2 = model_hex(v3, 3, 1'b1);
        @(negedge clk);
        for (int c = 0; c <= 40; c++) begin
            start_a = (c == 0) || (c == c2) || (c == c3);
            value_a = (c == 0) ? v1 : (c == c2) ? v2 : (c == c3) ? v3 : value_a;
            @(negedge clk);
            start_a = 1'b0;
            if (if_a.done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin c1st = c; h1 = if_a.hex; end
                else if (ndone == 2) begin c2nd = c; h2 = if_a.hex; end
            end
            if (c <= 33 && if_a.busy !== 1'b1) gaps++;
        end
        compared++;
        if (ndone !== 2) begin
            $display("FAIL %s done_count: got %0d want 2", name, ndone);
            mismatched++;
        end
        compared++;
        if (c1st !== 17 || c2nd !== 34) begin
            $display("FAIL %s done_cycles: got %0d,%0d want 17,34", name, c1st, c2nd);
            mismatched++;
        end
        compared++;
        if (h1 !== e1[20:0]) begin
            $display("FAIL %s first_hex: got %h want %h", name, h1, e1[20:0]);
            mismatched++;
        end
        compared++;
        if (h2 !== e2[20:0]) begin
            $display("FAIL %s second_hex: got %h want %h", name, h2, e2[20:0]);
            mismatched++;
        end
        compared++;
        if (gaps !== 0) begin
            $display("FAIL %s busy_gap: got %0d idle cycles want 0", name, gaps);
            mismatched++;
        end
    endtask

    task automatic test_back_to_back();
        int c2, c3;
        test_overlap(16'd123, 16'd456, 16'd789, 3, 5, "b2b");
        test_overlap(16'd11, 16'd22, 16'd1234, 4, 17, "bypass");
        for (int k = 0; k < 5; k++) begin
            c2 = $urandom_range(1, 15);
            c3 = $urandom_range(c2 + 1, 17);
            test_overlap(16'($urandom_range(0, 1200)), 16'($urandom_range(0, 1200)),
                         16'($urandom_range(0, 1200)), c2, c3, "rand_b2b");
        end
    endtask

    task automatic test_reset_mid();
        int          dones = 0;
        logic [48:0] ea;
        ea = model_hex(0, 3, 1'b1);
        drive_a(16'd999);
        repeat (8) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        compared++;
        if (if_a.busy !== 1'b0 || if_a.done !== 1'b0) begin
            $display("FAIL midreset flags: got busy=%b done=%b want 0 0", if_a.busy, if_a.done);
            mismatched++;
        end
        compared++;
        if (if_a.hex !== ea[20:0]) begin
            $display("FAIL midreset hex: got %h want %h", if_a.hex, ea[20:0]);
            mismatched++;
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (if_a.done === 1'b1) dones++;
        end
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (if_a.done === 1'b1 || if_a.busy === 1'b1) dones++;
        end
        compared++;
        if (dones !== 0) begin
            $display("FAIL midreset stale: got %0d done/busy cycles want 0", dones);
            mismatched++;
        end
        run_and_check_a(16'd42, "after_reset");
    endtask

    task automatic test_wide();
        logic [19:0] vals [5];
        logic [48:0] e6, e7;
        int          lat;
        vals[0] = 20'd1048575;
        vals[1] = 20'd999999;
        vals[2] = 20'd1000000;
        vals[3] = 20'($urandom_range(0, 1048575));
        vals[4] = 20'($urandom_range(0, 99999));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start_b = 1'b1;
            value_b = vals[k];
            @(negedge clk);
            start_b = 1'b0;
            lat = 0;
            while (if_7.done !== 1'b1 && lat < 60) begin
                @(negedge clk);
                lat++;
            end
            e6 = model_hex(vals[k], 6, 1'b1);
            e7 = model_hex(vals[k], 7, 1'b1);
            compared++;
            if (lat !== 21 || if_6.done !== 1'b1) begin
                $display("FAIL wide latency: got %0d done6=%b want 21 1", lat, if_6.done);
                mismatched++;
            end
            compared++;
            if (if_6.overflow !== model_ovf(vals[k], 6) || if_6.hex !== e6[41:0]) begin
                $display("FAIL wide6 %0d: got ovf=%b hex=%h want %b %h", vals[k],
                         if_6.overflow, if_6.hex, model_ovf(vals[k], 6), e6[41:0]);
                mismatched++;
            end
            compared++;
            if (if_7.overflow !== 1'b0 || if_7.hex !== e7) begin
                $display("FAIL wide7 %0d: got ovf=%b hex=%h want 0 %h", vals[k],
                         if_7.overflow, if_7.hex, e7);
                mismatched++;
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fixed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
